sti_dac_sequencer: RTL and testbench

Run controller for the STI_DAC serial-transmit / pixel-write datapath. On `start` it reads up to DEPTH pattern/stimulus word pairs from two synchronous ROMs, presents each pair to STI_DAC with a one-cycle `load` strobe, and waits for the serial burst to complete before moving on. After the last word it asserts `pi_end`, waits for `pixel_finish`, and reports `done`. It sits between the pattern ROMs and STI_DAC and replaces bench-driven stimulus in the integrated design.

---
 rtl/sti_dac_pkg.sv | 26 ++
 rtl/sti_dac_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sti_dac_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sti_dac_pkg.sv
// Shared types and constants for the STI_DAC run sequencer.
package sti_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_WAIT_V = 3'd4,
        ST_WAIT_D = 3'd5,
        ST_FINISH = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_e;

    // Bit positions of the control fields inside a stimulus ROM word.
    localparam int STI_LEN_HI = 13;
    localparam int STI_LEN_LO = 12;
    localparam int STI_FILL   = 8;
    localparam int STI_MSB    = 4;
    localparam int STI_LOW    = 0;

    localparam int DEF_DEPTH   = 100;
    localparam int DEF_AW      = 7;
    localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/sti_dac_sequencer.sv
// Run controller for STI_DAC: walks the pattern/stimulus ROMs, strobes each
// word pair into STI_DAC, waits for every serial burst, then closes the run
// with pi_end / pixel_finish / done.
// Optional watchdog on the wait states: define SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | rom_addr = word_cnt presented to both ROMs
// LATCH  | ROM data valid, captured into pi_* registers
// LOAD   | one-cycle load strobe to STI_DAC
// WAIT_V | waiting for so_valid to rise
// WAIT_D | waiting for so_valid to fall (burst complete)
// FINISH | pi_end held until pixel_finish
// DONE   | one-cycle done pulse, back to IDLE
module sti_dac_sequencer
    import sti_dac_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   pat_rdata,
    input  logic [15:0]   sti_rdata,
    output logic          load,
    output logic [15:0]   pi_data,
    output logic [1:0]    pi_length,
    output logic          pi_fill,
    output logic          pi_msb,
    output logic          pi_low,
    output logic          pi_end,
    input  logic          so_valid,
    input  logic          pixel_finish,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] word_cnt,
    output logic          err
);

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;
    logic [AW-1:0] r_word_cnt;
    logic [15:0]   r_pi_data;
    logic [1:0]    r_pi_length;
    logic          r_pi_fill;
    logic          r_pi_msb;
    logic          r_pi_low;
    logic          w_wd_expire;
    logic          w_err;
    logic          w_load;
    logic          w_done;
    logic          w_busy;
    logic          w_pi_end;
    logic          w_sti_unused;

    // Stimulus bits outside the control fields carry nothing for STI_DAC.
    assign w_sti_unused = ^{sti_rdata[15:14], sti_rdata[11:9], sti_rdata[7:5], sti_rdata[3:1]};

`ifdef SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] r_wd_cnt;
    logic           r_err;
    logic           w_wd_active;

    assign w_wd_active = (r_state == ST_WAIT_V) || (r_state == ST_WAIT_D) || (r_state == ST_FINISH);
    assign w_wd_expire = w_wd_active && (r_wd_cnt == '0);
    assign w_err       = r_err;

    // Watchdog down-counter, reloaded on every state change so each wait state gets a full window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wd_cnt <= WDW'(TIMEOUT - 1);
        end else if (w_wd_active && (r_wd_cnt != '0)) begin
            r_wd_cnt <= r_wd_cnt - 1'b1;
        end
    end

    // Sticky watchdog error, cleared only by an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_wd_expire) begin
            r_err <= 1'b1;
        end
    end
`else
    logic [31:0] w_timeout_unused;

    // Without the watchdog the limit has no effect and waits are unbounded.
    assign w_timeout_unused = 32'(TIMEOUT);
    assign w_wd_expire      = 1'b0;
    assign w_err            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        w_pi_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH:  w_state_nxt = ST_LATCH;
            ST_LATCH:  w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_WAIT_V;
            end
            ST_WAIT_V: begin
                if (w_wd_expire)   w_state_nxt = ST_DONE;
                else if (so_valid) w_state_nxt = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                if (w_wd_expire)    w_state_nxt = ST_DONE;
                else if (!so_valid) w_state_nxt = (r_word_cnt == LAST_WORD) ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: begin
                w_pi_end = 1'b1;
                if (w_wd_expire || pixel_finish) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_busy      = 1'b0;
                w_done      = 1'b1;
                w_pi_end    = w_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word index: cleared on an accepted start, advanced when a burst completes mid-run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_word_cnt <= '0;
        end else if ((r_state == ST_WAIT_D) && (w_state_nxt == ST_FETCH)) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    // Capture the ROM pair; held through the burst and after the run ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pi_data   <= '0;
            r_pi_length <= '0;
            r_pi_fill   <= 1'b0;
            r_pi_msb    <= 1'b0;
            r_pi_low    <= 1'b0;
        end else if (r_state == ST_LATCH) begin
            r_pi_data   <= pat_rdata;
            r_pi_length <= sti_rdata[STI_LEN_HI:STI_LEN_LO];
            r_pi_fill   <= sti_rdata[STI_FILL];
            r_pi_msb    <= sti_rdata[STI_MSB];
            r_pi_low    <= sti_rdata[STI_LOW];
        end
    end

    assign rom_addr  = r_word_cnt;
    assign word_cnt  = r_word_cnt;
    assign load      = w_load;
    assign done      = w_done;
    assign busy      = w_busy;
    assign pi_end    = w_pi_end;
    assign err       = w_err;
    assign pi_data   = r_pi_data;
    assign pi_length = r_pi_length;
    assign pi_fill   = r_pi_fill;
    assign pi_msb    = r_pi_msb;
    assign pi_low    = r_pi_low;

endmodule

// File: tb/tb_sti_dac_sequencer.sv
// Bench for sti_dac_sequencer: a DEPTH=3 and a DEPTH=1 instance share the
// ROM and STI_DAC models; sel picks which one is driven and observed.
// Expected timing is derived from cycle arithmetic on the burst schedule.
module tb_sti_dac_sequencer;

    localparam int AW  = 7;
    localparam int TMO = 16;
    localparam int BIG = 1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        so_valid = 1'b0;
    logic        pixel_finish = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] pat_rdata = '0;
    logic [15:0] sti_rdata = '0;
    logic [15:0] pat_rom [128];
    logic [15:0] sti_rom [128];

    logic start_a, start_b;
    logic [AW-1:0] a_rom_addr, b_rom_addr, a_word_cnt, b_word_cnt;
    logic [15:0]   a_pi_data, b_pi_data;
    logic [1:0]    a_pi_length, b_pi_length;
    logic a_load, a_pi_fill, a_pi_msb, a_pi_low, a_pi_end, a_busy, a_done, a_err;
    logic b_load, b_pi_fill, b_pi_msb, b_pi_low, b_pi_end, b_busy, b_done, b_err;

    logic [AW-1:0] rom_addr, word_cnt;
    logic [15:0]   pi_data;
    logic [1:0]    pi_length;
    logic load, pi_fill, pi_msb, pi_low, pi_end, busy, done, err;

    int total = 0;
    int bad = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    assign rom_addr  = sel ? b_rom_addr  : a_rom_addr;
    assign word_cnt  = sel ? b_word_cnt  : a_word_cnt;
    assign pi_data   = sel ? b_pi_data   : a_pi_data;
    assign pi_length = sel ? b_pi_length : a_pi_length;
    assign load      = sel ? b_load      : a_load;
    assign pi_fill   = sel ? b_pi_fill   : a_pi_fill;
    assign pi_msb    = sel ? b_pi_msb    : a_pi_msb;
    assign pi_low    = sel ? b_pi_low    : a_pi_low;
    assign pi_end    = sel ? b_pi_end    : a_pi_end;
    assign busy      = sel ? b_busy      : a_busy;
    assign done      = sel ? b_done      : a_done;
    assign err       = sel ? b_err       : a_err;

    sti_dac_sequencer #(.DEPTH(3), .AW(AW), .TIMEOUT(TMO)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .rom_addr(a_rom_addr),
        .pat_rdata(pat_rdata), .sti_rdata(sti_rdata), .load(a_load),
        .pi_data(a_pi_data), .pi_length(a_pi_length), .pi_fill(a_pi_fill),
        .pi_msb(a_pi_msb), .pi_low(a_pi_low), .pi_end(a_pi_end),
        .so_valid(so_valid), .pixel_finish(pixel_finish), .busy(a_busy),
        .done(a_done), .word_cnt(a_word_cnt), .err(a_err)
    );

    sti_dac_sequencer #(.DEPTH(1), .AW(AW), .TIMEOUT(TMO)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rom_addr(b_rom_addr),
        .pat_rdata(pat_rdata), .sti_rdata(sti_rdata), .load(b_load),
        .pi_data(b_pi_data), .pi_length(b_pi_length), .pi_fill(b_pi_fill),
        .pi_msb(b_pi_msb), .pi_low(b_pi_low), .pi_end(b_pi_end),
        .so_valid(so_valid), .pixel_finish(pixel_finish), .busy(b_busy),
        .done(b_done), .word_cnt(b_word_cnt), .err(b_err)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs: data for an address appears the cycle after it.
    always @(posedge clk) begin
        pat_rdata <= pat_rom[rom_addr];
        sti_rdata <= sti_rom[rom_addr];
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++;
            if ({load, pi_end, busy, done, err, rom_addr, word_cnt, pi_data, pi_length, pi_fill, pi_msb, pi_low} !== 40'd0) begin
                bad++;
                $display("FAIL reset_state sel=%0d got load=%0b end=%0b busy=%0b done=%0b err=%0b addr=%0d cnt=%0d data=%h exp all zero",
                         s, load, pi_end, busy, done, err, rom_addr, word_cnt, pi_data);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One run: random burst schedule, per-cycle check of load/pi_end/done/busy
    // against times computed from the schedule. abort_word >= 0 drops reset
    // during WAIT_D of that word instead of finishing the run.
    task automatic run_seq(input string name, input int depth, input bit force_d0,
                           input bit extra_start, input int abort_word);
        int cyc, exp_load, k, sv_on, sv_off, fin_cyc, pf_cyc, done_cyc, loads, dones, d, len;
        bit stop, aborted;
        exp_load = 3; k = 0; sv_on = -1; sv_off = -1;
        fin_cyc = BIG; pf_cyc = BIG; done_cyc = BIG;
        loads = 0; dones = 0; cyc = 0; stop = 1'b0; aborted = 1'b0;
        @(negedge clk);
        while (!stop) begin
            if (cyc > 400) begin
                total++; bad++;
                $display("FAIL %s run_timeout: no done after %0d cycles, required done pulse", name, cyc);
                stop = 1'b1;
            end else begin
                total++;
                if (load !== (cyc == exp_load)) begin
                    bad++; $display("FAIL %s load cyc=%0d got=%b exp=%0b", name, cyc, load, (cyc == exp_load));
                end
                total++;
                if (pi_end !== (cyc >= fin_cyc && cyc < done_cyc)) begin
                    bad++; $display("FAIL %s pi_end cyc=%0d got=%b exp=%0b", name, cyc, pi_end, (cyc >= fin_cyc && cyc < done_cyc));
                end
                total++;
                if (done !== (cyc == done_cyc)) begin
                    bad++; $display("FAIL %s done cyc=%0d got=%b exp=%0b", name, cyc, done, (cyc == done_cyc));
                end
                total++;
                if (busy !== (cyc >= 1 && cyc < done_cyc)) begin
                    bad++; $display("FAIL %s busy cyc=%0d got=%b exp=%0b", name, cyc, busy, (cyc >= 1 && cyc < done_cyc));
                end
                if (cyc >= 1) begin
                    total++;
                    if (err !== 1'b0) begin
                        bad++; $display("FAIL %s err cyc=%0d got=%b exp=0", name, cyc, err);
                    end
                end
                if (cyc == 1) begin
                    total++;
                    if (rom_addr !== '0) begin
                        bad++; $display("FAIL %s first_addr got=%0d exp=0", name, rom_addr);
                    end
                end
                if (load === 1'b1) loads++;
                if (done === 1'b1) dones++;
                if (cyc == exp_load) begin
                    total++;
                    if (pi_data !== pat_rom[k]) begin
                        bad++; $display("FAIL %s pi_data word=%0d got=%h exp=%h", name, k, pi_data, pat_rom[k]);
                    end
                    total++;
                    if ({pi_length, pi_fill, pi_msb, pi_low} !== {sti_rom[k][13:12], sti_rom[k][8], sti_rom[k][4], sti_rom[k][0]}) begin
                        bad++;
                        $display("FAIL %s pi_fields word=%0d got=%b exp=%b", name, k, {pi_length, pi_fill, pi_msb, pi_low},
                                 {sti_rom[k][13:12], sti_rom[k][8], sti_rom[k][4], sti_rom[k][0]});
                    end
                    total++;
                    if (word_cnt !== AW'(k)) begin
                        bad++; $display("FAIL %s word_cnt got=%0d exp=%0d", name, word_cnt, k);
                    end
                    d = force_d0 ? 0 : int'($urandom_range(0, 3));
                    len = (d == 0) ? int'($urandom_range(2, 8)) : int'($urandom_range(1, 8));
                    sv_on = cyc + d;
                    sv_off = sv_on + len;
                    if (k == depth - 1) begin
                        fin_cyc = sv_off + 1;
                        pf_cyc = fin_cyc + int'($urandom_range(0, 6));
                        done_cyc = pf_cyc + 1;
                        exp_load = BIG;
                    end else begin
                        exp_load = sv_off + 3;
                    end
                    k++;
                end
                if (abort_word >= 0 && k == abort_word + 1 && cyc == sv_off) begin
                    reset = 1'b0;
                    #1;
                    total++;
                    if ({load, pi_end, busy, done, err, rom_addr, word_cnt, pi_data, pi_length, pi_fill, pi_msb, pi_low} !== 40'd0) begin
                        bad++;
                        $display("FAIL %s async_reset got load=%0b end=%0b busy=%0b done=%0b addr=%0d cnt=%0d data=%h exp all zero",
                                 name, load, pi_end, busy, done, rom_addr, word_cnt, pi_data);
                    end
                    start = 1'b0; so_valid = 1'b0; pixel_finish = 1'b0;
                    aborted = 1'b1;
                    stop = 1'b1;
                end else begin
                    start = (cyc == 0) || (extra_start && (cyc == 4 || cyc == done_cyc));
                    so_valid = (cyc >= sv_on && cyc < sv_off);
                    pixel_finish = (cyc < fin_cyc) ? 1'($urandom_range(0, 1)) : (cyc >= pf_cyc && cyc < done_cyc);
                    @(negedge clk);
                    cyc++;
                    if (cyc > done_cyc + 2) stop = 1'b1;
                end
            end
        end
        start = 1'b0; so_valid = 1'b0; pixel_finish = 1'b0;
        if (aborted) begin
            @(negedge clk);
            total++;
            if ({busy, done, pi_end} !== 3'b000) begin
                bad++; $display("FAIL %s reset_hold got busy=%b done=%b end=%b exp 000", name, busy, done, pi_end);
            end
            reset = 1'b1;
            @(negedge clk);
        end else begin
            total++;
            if (loads != depth) begin
                bad++; $display("FAIL %s load_count got=%0d exp=%0d", name, loads, depth);
            end
            total++;
            if (dones != 1) begin
                bad++; $display("FAIL %s done_count got=%0d exp=1", name, dones);
            end
            total++;
            if (word_cnt !== AW'(depth - 1)) begin
                bad++; $display("FAIL %s final_word_cnt got=%0d exp=%0d", name, word_cnt, depth - 1);
            end
        end
    endtask

    task automatic test_depth3();
        for (int r = 0; r < 4; r++) run_seq("depth3", 3, 1'b0, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        run_seq("start_ignore", 3, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_run();
        run_seq("abort_word1", 3, 1'b0, 1'b0, 1);
        run_seq("restart", 3, 1'b0, 1'b0, -1);
    endtask

    task automatic test_depth1();
        sel = 1'b1;
        run_seq("depth1_early_valid", 1, 1'b1, 1'b0, -1);
        total++;
        if ({pi_data, pi_length, pi_fill, pi_msb, pi_low} !== {16'hA5C3, 2'd3, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL word0_hold got data=%h len=%0d fill=%b msb=%b low=%b exp data=a5c3 len=3 fill=1 msb=1 low=1",
                     pi_data, pi_length, pi_fill, pi_msb, pi_low);
        end
        for (int r = 0; r < 3; r++) run_seq("depth1", 1, 1'b0, 1'b0, -1);
        sel = 1'b0;
        #1;
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        sel = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (cyc <= 23) begin
            total++;
            if (done !== (cyc == 4 + TMO)) begin
                bad++; $display("FAIL timeout_done cyc=%0d got=%b exp=%0b", cyc, done, (cyc == 4 + TMO));
            end
            if (cyc == 4 + TMO) begin
                total++;
                if ({err, pi_end} !== 2'b11) begin
                    bad++; $display("FAIL timeout_flags got err=%b pi_end=%b exp err=1 pi_end=1", err, pi_end);
                end
            end
            if (cyc == 23) begin
                total++;
                if (err !== 1'b1) begin
                    bad++; $display("FAIL timeout_sticky got err=%b exp=1", err);
                end
            end
            start = (cyc == 0);
            so_valid = 1'b0;
            pixel_finish = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        run_seq("after_timeout", 3, 1'b0, 1'b0, -1);
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) begin
            pat_rom[i] = 16'($urandom);
            sti_rom[i] = 16'($urandom);
        end
        pat_rom[0] = 16'hA5C3;
        sti_rom[0] = 16'h3111;

        test_reset();
        test_depth3();
        test_start_ignored();
        test_reset_mid_run();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_depth1();
        test_depth3();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
